// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/mem/writeback.
// Latency: outputs follow State combinationally; instructions take 3-5 cycles, illegal ops 2.
// No backpressure: advances every cycle; reset gates all write enables immediately.
module mc_ctrl_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] AluOp,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       InstrDone,
    output logic       Illegal,
    output logic [3:0] State
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMRD    = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWR    = 4'd5;
    localparam logic [3:0] EXECUTE  = 4'd6;
    localparam logic [3:0] ALUWB    = 4'd7;
    localparam logic [3:0] BEQ      = 4'd8;
    localparam logic [3:0] ADDIEXEC = 4'd9;
    localparam logic [3:0] ADDIWB   = 4'd10;
    localparam logic [3:0] JUMP     = 4'd11;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       op_legal;
    logic       memwrite_raw;
    logic       irwrite_raw;
    logic       pcwrite_raw;
    logic       branch_raw;
    logic       regwrite_raw;

    always_comb begin
        op_legal = (Op == OP_LW) || (Op == OP_SW) || (Op == OP_RTYPE) ||
                   (Op == OP_BEQ) || (Op == OP_ADDI) || (Op == OP_J);
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            // Op is re-sampled here; anything other than lw/sw abandons the access.
            MEMADR: begin
                if (Op == OP_LW)      state_d = MEMRD;
                else if (Op == OP_SW) state_d = MEMWR;
                else                  state_d = FETCH;
            end
            MEMRD:    state_d = MEMWB;
            EXECUTE:  state_d = ALUWB;
            ADDIEXEC: state_d = ADDIWB;
            default:  state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        IorD         = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        pcwrite_raw  = 1'b0;
        branch_raw   = 1'b0;
        PCSrc        = 2'b00;
        AluSrcA      = 1'b0;
        AluSrcB      = 2'b00;
        AluOp        = 2'b00;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        regwrite_raw = 1'b0;
        InstrDone    = 1'b0;
        Illegal      = 1'b0;
        case (state_q)
            FETCH: begin
                irwrite_raw = 1'b1;
                pcwrite_raw = 1'b1;
                AluSrcB     = 2'b01;
            end
            DECODE: begin
                AluSrcB = 2'b11;
                Illegal = ~op_legal;
            end
            MEMADR, ADDIEXEC: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'b10;
            end
            MEMRD: IorD = 1'b1;
            MEMWB: begin
                regwrite_raw = 1'b1;
                MemtoReg     = 1'b1;
                InstrDone    = 1'b1;
            end
            MEMWR: begin
                IorD         = 1'b1;
                memwrite_raw = 1'b1;
                InstrDone    = 1'b1;
            end
            EXECUTE: begin
                AluSrcA = 1'b1;
                AluOp   = 2'b10;
            end
            ALUWB: begin
                regwrite_raw = 1'b1;
                RegDst       = 1'b1;
                InstrDone    = 1'b1;
            end
            BEQ: begin
                AluSrcA    = 1'b1;
                AluOp      = 2'b01;
                PCSrc      = 2'b01;
                branch_raw = 1'b1;
                InstrDone  = 1'b1;
            end
            ADDIWB: begin
                regwrite_raw = 1'b1;
                InstrDone    = 1'b1;
            end
            JUMP: begin
                pcwrite_raw = 1'b1;
                PCSrc       = 2'b10;
                InstrDone   = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are suppressed as long as reset is held, whatever the state.
    assign MemWrite = memwrite_raw & ~reset;
    assign IRWrite  = irwrite_raw  & ~reset;
    assign PCWrite  = pcwrite_raw  & ~reset;
    assign Branch   = branch_raw   & ~reset;
    assign RegWrite = regwrite_raw & ~reset;
    assign State    = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed and random instruction streams against a trace/control-table model.
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       IorD, MemWrite, IRWrite, PCWrite, Branch;
    logic [1:0] PCSrc;
    logic       AluSrcA;
    logic [1:0] AluSrcB, AluOp;
    logic       RegDst, MemtoReg, RegWrite, InstrDone, Illegal;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk(clk), .reset(reset), .Op(Op),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Branch(Branch), .PCSrc(PCSrc), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
        .AluOp(AluOp), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .InstrDone(InstrDone), .Illegal(Illegal), .State(State)
    );

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       instrdone;
        logic       illegal;
    } ctrl_t;

    ctrl_t dut_c;
    assign dut_c = {IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, AluSrcA, AluSrcB,
                    AluOp, RegDst, MemtoReg, RegWrite, InstrDone, Illegal};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010;

    logic [5:0] legal_ops [6] = '{LW, SW, RT, BQ, AI, JJ};
    int trace [$];

    function automatic bit is_legal(input logic [5:0] op);
        foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Expected state walk of one instruction, starting at FETCH.
    function automatic void build_trace(input logic [5:0] op);
        trace = {0, 1};
        case (op)
            LW: trace = {trace, 2, 3, 4};
            SW: trace = {trace, 2, 5};
            RT: trace = {trace, 6, 7};
            BQ: trace = {trace, 8};
            AI: trace = {trace, 9, 10};
            JJ: trace = {trace, 11};
            default: ;
        endcase
    endfunction

    // Control word table per state; bad_op only matters in DECODE.
    function automatic ctrl_t exp_ctrl(input int s, input bit bad_op, input bit rst);
        ctrl_t c = '0;
        case (s)
            0:  begin c.irwrite = 1; c.pcwrite = 1; c.alusrcb = 2'b01; end
            1:  begin c.alusrcb = 2'b11; c.illegal = bad_op; end
            2, 9: begin c.alusrca = 1; c.alusrcb = 2'b10; end
            3:  c.iord = 1;
            4:  begin c.regwrite = 1; c.memtoreg = 1; c.instrdone = 1; end
            5:  begin c.iord = 1; c.memwrite = 1; c.instrdone = 1; end
            6:  begin c.alusrca = 1; c.aluop = 2'b10; end
            7:  begin c.regwrite = 1; c.regdst = 1; c.instrdone = 1; end
            8:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1; c.instrdone = 1; end
            10: begin c.regwrite = 1; c.instrdone = 1; end
            11: begin c.pcwrite = 1; c.pcsrc = 2'b10; c.instrdone = 1; end
            default: ;
        endcase
        if (rst) begin
            c.irwrite = 0; c.pcwrite = 0; c.memwrite = 0; c.regwrite = 0; c.branch = 0;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Op = LW;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (State !== 4'd0) begin
                errors++; $display("FAIL reset_state cyc%0d got %0d want 0", c, State);
            end
            checks++;
            if (dut_c !== exp_ctrl(0, 0, 1)) begin
                errors++; $display("FAIL reset_ctrl cyc%0d got %h want %h", c, dut_c, exp_ctrl(0, 0, 1));
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
            errors++; $display("FAIL first_fetch_we got IRWrite=%b PCWrite=%b want 1 1", IRWrite, PCWrite);
        end
    endtask

    task automatic test_directed();
        logic [5:0] ops [7] = '{LW, SW, RT, BQ, JJ, 6'b111111, AI};
        int lat [7] = '{5, 4, 4, 3, 3, 2, 4};
        int cnt;
        foreach (ops[k]) begin
            build_trace(ops[k]);
            Op = ops[k];
            foreach (trace[i]) begin
                #1;
                checks++;
                if (State !== 4'(trace[i])) begin
                    errors++; $display("FAIL dir_state op=%b step%0d got %0d want %0d", ops[k], i, State, trace[i]);
                end
                checks++;
                if (dut_c !== exp_ctrl(trace[i], !is_legal(ops[k]), 0)) begin
                    errors++; $display("FAIL dir_ctrl op=%b step%0d got %h want %h", ops[k], i, dut_c,
                                       exp_ctrl(trace[i], !is_legal(ops[k]), 0));
                end
                tick();
            end
            #1;
            checks++;
            if (State !== 4'd0) begin
                errors++; $display("FAIL dir_end op=%b got %0d want 0", ops[k], State);
            end
        end
        foreach (ops[k]) begin
            Op = ops[k];
            tick();
            cnt = 1;
            while (State !== 4'd0 && cnt < 12) begin
                tick();
                cnt++;
            end
            checks++;
            if (cnt != lat[k]) begin
                errors++; $display("FAIL latency op=%b got %0d want %0d", ops[k], cnt, lat[k]);
            end
        end
    endtask

    task automatic test_memadr_resample();
        Op = SW;
        tick();
        tick();
        Op = RT;
        #1;
        checks++;
        if (State !== 4'd2) begin
            errors++; $display("FAIL memadr_reach got %0d want 2", State);
        end
        tick();
        checks++;
        if (State !== 4'd0) begin
            errors++; $display("FAIL memadr_defensive got %0d want 0", State);
        end
        Op = LW;
        tick();
        tick();
        Op = SW;
        tick();
        checks++;
        if (State !== 4'd5) begin
            errors++; $display("FAIL memadr_resample got %0d want 5", State);
        end
        tick();
    endtask

    task automatic test_reset_midinstr();
        Op = LW;
        tick(); tick(); tick();
        checks++;
        if (State !== 4'd3) begin
            errors++; $display("FAIL mid_reach got %0d want 3", State);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (dut_c !== exp_ctrl(3, 0, 1)) begin
            errors++; $display("FAIL mid_gate got %h want %h", dut_c, exp_ctrl(3, 0, 1));
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (State !== 4'd0 || dut_c !== exp_ctrl(0, 0, 1)) begin
                errors++; $display("FAIL mid_reset cyc%0d got st=%0d c=%h want st=0 c=%h", c, State, dut_c, exp_ctrl(0, 0, 1));
            end
        end
        reset = 1'b0;
        Op = AI;
        build_trace(AI);
        foreach (trace[i]) begin
            #1;
            checks++;
            if (State !== 4'(trace[i]) || dut_c !== exp_ctrl(trace[i], 0, 0)) begin
                errors++; $display("FAIL addi step%0d got st=%0d c=%h want st=%0d c=%h", i, State, dut_c,
                                   trace[i], exp_ctrl(trace[i], 0, 0));
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [5:0] op;
        bit aborted;
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 7) < 6) op = legal_ops[$urandom_range(0, 5)];
            else begin
                do op = 6'($urandom); while (is_legal(op));
            end
            build_trace(op);
            aborted = 0;
            foreach (trace[i]) begin
                if (!aborted) begin
                    Op = (trace[i] == 1 || trace[i] == 2) ? op : 6'($urandom);
                    if ($urandom_range(0, 39) == 0) begin
                        reset = 1'b1;
                        aborted = 1;
                    end
                    #1;
                    checks++;
                    if (State !== 4'(trace[i])) begin
                        errors++; $display("FAIL rnd_state n%0d op=%b step%0d got %0d want %0d", n, op, i, State, trace[i]);
                    end
                    checks++;
                    if (dut_c !== exp_ctrl(trace[i], !is_legal(Op), reset)) begin
                        errors++; $display("FAIL rnd_ctrl n%0d op=%b step%0d rst=%b got %h want %h", n, op, i, reset,
                                           dut_c, exp_ctrl(trace[i], !is_legal(Op), reset));
                    end
                    tick();
                    reset = 1'b0;
                end
            end
        end
        #1;
        checks++;
        if (State !== 4'd0) begin
            errors++; $display("FAIL rnd_end got %0d want 0", State);
        end
    endtask

    initial begin
        reset = 1'b1;
        Op = 6'd0;
        test_reset();
        test_directed();
        test_memadr_resample();
        test_reset_midinstr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
